multi_zone_shutdown_timer: RTL and testbench
============================================

Name: multi_zone_shutdown_timer

Overview:
- Parametrised, multi-zone successor to the single-channel auto-shutdown controller in the smart-lighting datapath.
- Tracks N lighting zones independently. Each zone has its own presence (infrared) input, runtime-programmable timeout, pre-shutdown warning window, one-cycle shutdown pulse and lamp-on level.
- Sits between the sensor conditioning stage and the lamp driver / PWM stage. Counts a shared timebase tick, not raw clocks.

Parameters:
- N_ZONES, 4, number of independent zones (1..16).
- CNT_W, 16, width of per-zone counter and timeout registers.
- DEFAULT_T, 30000, timeout loaded into every zone at reset, in ticks.
- WARN_T, 1000, length of the warning window before expiry, in ticks; 0 disables warning.
- ZONE_W, 2, width of cfg_zone; must satisfy 2**ZONE_W >= N_ZONES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick  in  1  shared timebase strobe; counters advance only on cycles with tick=1.
- infravermelho  in  N_ZONES  per-zone presence, 1 = occupant detected.
- enable  in  N_ZONES  per-zone count enable; 0 freezes that zone's counter (no clear).
- cfg_we  in  1  timeout write strobe.
- cfg_zone  in  ZONE_W  target zone of the write.
- cfg_value  in  CNT_W  new timeout in ticks.
- lamp_on  out  N_ZONES  1 while zone is in IDLE, COUNTING or WARN.
- warn  out  N_ZONES  1 while zone is in WARN.
- shutdown  out  N_ZONES  one-cycle pulse on expiry.
- any_active  out  1  OR of lamp_on.

Behaviour:
- Reset (rst=0, asynchronous):
  - All zones enter IDLE; counters cleared; every limit register set to DEFAULT_T.
  - Outputs: lamp_on all 1, warn 0, shutdown 0, any_active 1.
  - Reset mid-count aborts the count with no shutdown pulse.
- Per-zone FSM, all transitions registered. States are IDLE, COUNTING, WARN, EXPIRE, OFF.
  - IDLE: counter = 0. infravermelho[i]=0 → COUNTING on the next edge. Stays in IDLE while infravermelho[i]=1.
  - COUNTING: on tick & enable[i], counter += 1. infravermelho[i]=1 → IDLE and counter = 0; presence has priority over tick in the same cycle. Enters WARN when counter+1 would reach limit−WARN_T. If WARN_T=0 or WARN_T ≥ limit, goes straight to EXPIRE on reaching limit.
  - WARN: counts like COUNTING. Presence → IDLE, clear counter. When counter reaches limit (the increment that makes counter == limit) → EXPIRE.
  - EXPIRE: shutdown[i]=1 for exactly one cycle, lamp_on[i]=0. Always → OFF next cycle, regardless of inputs.
  - OFF: lamp_on[i]=0, counter = 0. infravermelho[i]=1 → IDLE.
- Latency:
  - Shutdown pulse is asserted the cycle after the clock edge on which the limit-th qualifying tick is sampled.
  - Presence-to-lamp_on recovery from OFF is 1 cycle.
- Counter arithmetic: unsigned CNT_W; never wraps, saturates at limit.
- Timeout configuration:
  - On cfg_we=1 the limit of cfg_zone is replaced on the next edge.
  - cfg_value=0 is stored as 1.
  - cfg_zone ≥ N_ZONES: write ignored.
  - The new limit takes effect immediately. If the running counter ≥ new limit, the zone goes to EXPIRE at the next qualifying tick.
  - A write to a zone does not restart or clear its counter.
- Zones are fully independent. Simultaneous expiries in multiple zones produce simultaneous pulses.
- Unused encodings return to IDLE.

Optional Feature:
- Macro: MANUAL_OVERRIDE_EN.
- When defined: adds input port override (N_ZONES).
  - override[i]=1 forces zone i to IDLE and holds it there with counter cleared; lamp_on=1, warn=0, no shutdown pulse.
  - Releasing override resumes normal FSM from IDLE.
- When undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset with DEFAULT_T=20, WARN_T=5, tick every cycle, all infravermelho=0 → each zone: warn rises when counter reaches 15; shutdown pulses for exactly one cycle after the 20th tick; lamp_on=0 afterwards; any_active=0.
- Zone 1 presence asserted at counter=12 → zone 1 returns to IDLE with counter 0, no pulse. Other zones still expire on schedule.
- cfg_we, zone 2, cfg_value=8 while zone 2 counter=10 → zone 2 expires on the next tick. cfg_value=0 to zone 3 → expires after 1 tick. cfg_zone=7 with N_ZONES=4 → no limit changes.
- enable[0]=0 for 10 cycles mid-count → counter frozen; expiry delayed by exactly 10 ticks. tick low every other cycle → expiry takes 2× clocks.
- Zone in OFF, infravermelho=1 for 1 cycle → lamp_on=1 next cycle. Then presence released → full 20-tick countdown again.
- rst=0 asynchronously while in WARN → outputs go to reset values immediately with no shutdown pulse. With MANUAL_OVERRIDE_EN, override held through expiry point → no pulse, lamp_on stays 1.

Source files
------------

// File: rtl/multi_zone_shutdown_timer.sv
// Multi-zone lighting auto-shutdown: each zone counts timebase ticks while vacant,
// warns before expiry, pulses shutdown once, then stays dark until presence returns.
// Optional feature macro: MANUAL_OVERRIDE_EN adds an `override` input that pins zones in IDLE.
//
// state    | meaning
// IDLE     | occupant present (or just returned), counter held at 0, lamp on
// COUNTING | zone vacant, counting qualifying ticks toward the warning window
// WARN     | inside the warning window, still counting, lamp on
// EXPIRE   | one-cycle shutdown pulse, lamp off
// OFF      | lamp off, counter 0, waiting for presence
module multi_zone_shutdown_timer #(
  parameter int N_ZONES   = 4,
  parameter int CNT_W     = 16,
  parameter int DEFAULT_T = 30000,
  parameter int WARN_T    = 1000,
  parameter int ZONE_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_ZONES-1:0]  infravermelho,
  input  logic [N_ZONES-1:0]  enable,
`ifdef MANUAL_OVERRIDE_EN
  input  logic [N_ZONES-1:0]  override,
`endif
  input  logic                cfg_we,
  input  logic [ZONE_W-1:0]   cfg_zone,
  input  logic [CNT_W-1:0]    cfg_value,
  output logic [N_ZONES-1:0]  lamp_on,
  output logic [N_ZONES-1:0]  warn,
  output logic [N_ZONES-1:0]  shutdown,
  output logic                any_active
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COUNTING = 3'd1,
    S_WARN     = 3'd2,
    S_EXPIRE   = 3'd3,
    S_OFF      = 3'd4
  } state_t;

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] cnt;
  } zone_t;

  localparam logic [CNT_W-1:0] DEFAULT_LIM = (DEFAULT_T == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_T);
  localparam logic [31:0]      WARN_U      = 32'(WARN_T);
  localparam zone_t            ZONE_RST    = '{st: S_IDLE, cnt: '0};

  zone_t                zone_q [N_ZONES];
  zone_t                zone_d [N_ZONES];
  logic [CNT_W-1:0]     limit_q [N_ZONES];
  logic [N_ZONES-1:0]   lamp_on_q;
  logic [N_ZONES-1:0]   warn_q;
  logic [N_ZONES-1:0]   shutdown_q;

  // Comparisons use >= against the limit so a limit lowered below the running
  // count still expires on the very next qualifying tick.
  function automatic zone_t zone_next(input zone_t            cur,
                                      input logic [CNT_W-1:0] lim,
                                      input logic             pres,
                                      input logic             step);
    zone_t       nxt;
    logic [31:0] inc;
    logic [31:0] lim32;
    logic        warn_en;
    nxt     = cur;
    lim32   = 32'(lim);
    inc     = 32'(cur.cnt) + 32'd1;
    warn_en = (WARN_U != 32'd0) && (WARN_U < lim32);
    case (cur.st)
      S_IDLE: begin
        nxt.cnt = '0;
        if (!pres) nxt.st = S_COUNTING;
      end
      S_COUNTING, S_WARN: begin
        if (pres) begin
          nxt.st  = S_IDLE;
          nxt.cnt = '0;
        end else if (step) begin
          if (inc >= lim32) begin
            nxt.st  = S_EXPIRE;
            nxt.cnt = lim;
          end else begin
            nxt.cnt = CNT_W'(inc);
            if (warn_en && (inc >= lim32 - WARN_U)) nxt.st = S_WARN;
          end
        end
      end
      S_EXPIRE: begin
        nxt.st  = S_OFF;
        nxt.cnt = '0;
      end
      S_OFF: begin
        nxt.cnt = '0;
        if (pres) nxt.st = S_IDLE;
      end
      default: nxt = ZONE_RST;
    endcase
    return nxt;
  endfunction

  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      zone_d[i] = zone_next(zone_q[i], limit_q[i], infravermelho[i], tick & enable[i]);
`ifdef MANUAL_OVERRIDE_EN
      if (override[i]) zone_d[i] = ZONE_RST;
`endif
    end
  end

  // Writes to zones beyond N_ZONES match no index and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_ZONES; i++) begin
        zone_q[i]  <= ZONE_RST;
        limit_q[i] <= DEFAULT_LIM;
      end
      lamp_on_q  <= '1;
      warn_q     <= '0;
      shutdown_q <= '0;
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        zone_q[i]     <= zone_d[i];
        lamp_on_q[i]  <= (zone_d[i].st == S_IDLE) || (zone_d[i].st == S_COUNTING) ||
                         (zone_d[i].st == S_WARN);
        warn_q[i]     <= (zone_d[i].st == S_WARN);
        shutdown_q[i] <= (zone_d[i].st == S_EXPIRE);
        if (cfg_we && (int'(cfg_zone) == i))
          limit_q[i] <= (cfg_value == '0) ? CNT_W'(1) : cfg_value;
      end
    end
  end

  assign lamp_on    = lamp_on_q;
  assign warn       = warn_q;
  assign shutdown   = shutdown_q;
  assign any_active = |lamp_on_q;

endmodule

// File: tb/tb_multi_zone_shutdown_timer.sv
// Bench for multi_zone_shutdown_timer: directed scenarios plus randomized traffic,
// all checked against a tick-level occupancy model of each zone.
module tb_multi_zone_shutdown_timer;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int DT = 20;
  localparam int WT = 5;
  localparam int ZW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b1;
  logic [N-1:0]  infra = '0;
  logic [N-1:0]  en = '1;
  logic [N-1:0]  ovr = '0;
  logic          cfg_we = 1'b0;
  logic [ZW-1:0] cfg_zone = '0;
  logic [CW-1:0] cfg_value = '0;
  logic [N-1:0]  lamp_on, warn, shutdown;
  logic          any_active;

  int vecs = 0;
  int miscompares = 0;

  multi_zone_shutdown_timer #(
    .N_ZONES(N), .CNT_W(CW), .DEFAULT_T(DT), .WARN_T(WT), .ZONE_W(ZW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .infravermelho(infra), .enable(en),
`ifdef MANUAL_OVERRIDE_EN
    .override(ovr),
`endif
    .cfg_we(cfg_we), .cfg_zone(cfg_zone), .cfg_value(cfg_value),
    .lamp_on(lamp_on), .warn(warn), .shutdown(shutdown), .any_active(any_active)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = lit & occupied, 1 = lit & timing out, 2 = pulse, 3 = dark.
  int m_ph[N];
  int m_cnt[N];
  int m_lim[N];
  bit m_warned[N];

  function automatic void model_reset();
    for (int z = 0; z < N; z++) begin
      m_ph[z] = 0; m_cnt[z] = 0; m_lim[z] = DT; m_warned[z] = 1'b0;
    end
  endfunction

  function automatic void model_step();
    int nl[N];
    if (!rst) begin
      model_reset();
      return;
    end
    for (int z = 0; z < N; z++) nl[z] = m_lim[z];
    if (cfg_we && int'(cfg_zone) < N) nl[cfg_zone] = (cfg_value == 0) ? 1 : int'(cfg_value);
    for (int z = 0; z < N; z++) begin
      if (ovr[z]) begin
        m_ph[z] = 0; m_cnt[z] = 0; m_warned[z] = 1'b0;
      end else begin
        case (m_ph[z])
          0: if (!infra[z]) begin m_ph[z] = 1; m_cnt[z] = 0; m_warned[z] = 1'b0; end
          1: begin
            if (infra[z]) begin
              m_ph[z] = 0; m_cnt[z] = 0; m_warned[z] = 1'b0;
            end else if (tick && en[z]) begin
              if (m_cnt[z] + 1 >= m_lim[z]) m_ph[z] = 2;
              else begin
                m_cnt[z]++;
                if (WT > 0 && WT < m_lim[z] && m_cnt[z] >= m_lim[z] - WT) m_warned[z] = 1'b1;
              end
            end
          end
          2: m_ph[z] = 3;
          default: if (infra[z]) m_ph[z] = 0;
        endcase
      end
    end
    for (int z = 0; z < N; z++) m_lim[z] = nl[z];
  endfunction

  function automatic logic [3*N:0] model_outs();
    logic [N-1:0] l, w, s;
    for (int z = 0; z < N; z++) begin
      l[z] = (m_ph[z] <= 1);
      w[z] = (m_ph[z] == 1) && m_warned[z];
      s[z] = (m_ph[z] == 2);
    end
    return {l, w, s, |l};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] pres);
    rst = 1'b0; infra = pres; tick = 1'b1; en = '1; ovr = '0; cfg_we = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    vecs++;
    if ({lamp_on, warn, shutdown, any_active} !== {4'hF, 4'h0, 4'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_values got=%h want=%h", {lamp_on, warn, shutdown, any_active}, 13'h1E01);
    end
    do_reset('0);
    vecs++;
    if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=%h", {lamp_on, warn, shutdown, any_active}, model_outs());
    end
  endtask

  task automatic test_basic_expiry();
    int first_warn[N], first_sd[N], pulses[N];
    do_reset('0);
    for (int z = 0; z < N; z++) begin first_warn[z] = -1; first_sd[z] = -1; pulses[z] = 0; end
    for (int k = 1; k <= 24; k++) begin
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL basic cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
      for (int z = 0; z < N; z++) begin
        if (warn[z] && first_warn[z] < 0) first_warn[z] = k;
        if (shutdown[z]) begin pulses[z]++; if (first_sd[z] < 0) first_sd[z] = k; end
      end
    end
    for (int z = 0; z < N; z++) begin
      vecs++;
      if (first_warn[z] != 16 || first_sd[z] != 21 || pulses[z] != 1) begin
        miscompares++;
        $display("FAIL basic_timing z=%0d warn_at=%0d sd_at=%0d pulses=%0d want 16/21/1",
                 z, first_warn[z], first_sd[z], pulses[z]);
      end
    end
    vecs++;
    if (lamp_on !== 4'h0 || any_active !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_dark lamp_on=%h any_active=%b want 0/0", lamp_on, any_active);
    end
  endtask

  task automatic test_presence_abort();
    int first_sd[N];
    int want[N] = '{21, 35, 21, 21};
    do_reset('0);
    for (int z = 0; z < N; z++) first_sd[z] = -1;
    for (int k = 1; k <= 40; k++) begin
      infra[1] = (k == 14);
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL presence cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
      for (int z = 0; z < N; z++) if (shutdown[z] && first_sd[z] < 0) first_sd[z] = k;
    end
    for (int z = 0; z < N; z++) begin
      vecs++;
      if (first_sd[z] != want[z]) begin
        miscompares++;
        $display("FAIL presence_timing z=%0d sd_at=%0d want=%0d", z, first_sd[z], want[z]);
      end
    end
  endtask

  task automatic test_cfg();
    int first_sd[N];
    int want[N] = '{21, 21, 13, 2};
    do_reset('1);
    cfg_we = 1'b1; cfg_zone = 3'd3; cfg_value = 8'd0; step();
    cfg_zone = 3'd7; cfg_value = 8'd3; step();
    cfg_zone = 3'd5; cfg_value = 8'd2; step();
    cfg_we = 1'b0; infra = '0;
    for (int z = 0; z < N; z++) first_sd[z] = -1;
    for (int k = 1; k <= 24; k++) begin
      cfg_we = (k == 12); cfg_zone = 3'd2; cfg_value = 8'd8;
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL cfg cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
      for (int z = 0; z < N; z++) if (shutdown[z] && first_sd[z] < 0) first_sd[z] = k;
    end
    cfg_we = 1'b0;
    for (int z = 0; z < N; z++) begin
      vecs++;
      if (first_sd[z] != want[z]) begin
        miscompares++;
        $display("FAIL cfg_timing z=%0d sd_at=%0d want=%0d", z, first_sd[z], want[z]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    int first_sd[N];
    int want[N] = '{31, 21, 21, 21};
    do_reset('0);
    for (int z = 0; z < N; z++) first_sd[z] = -1;
    for (int k = 1; k <= 34; k++) begin
      en[0] = !(k >= 6 && k <= 15);
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL enable cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
      for (int z = 0; z < N; z++) if (shutdown[z] && first_sd[z] < 0) first_sd[z] = k;
    end
    en = '1;
    for (int z = 0; z < N; z++) begin
      vecs++;
      if (first_sd[z] != want[z]) begin
        miscompares++;
        $display("FAIL enable_timing z=%0d sd_at=%0d want=%0d", z, first_sd[z], want[z]);
      end
    end
  endtask

  task automatic test_tick_half();
    int first_sd[N];
    do_reset('0);
    for (int z = 0; z < N; z++) first_sd[z] = -1;
    for (int k = 1; k <= 44; k++) begin
      tick = (k % 2 == 0);
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL tick_half cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
      for (int z = 0; z < N; z++) if (shutdown[z] && first_sd[z] < 0) first_sd[z] = k;
    end
    tick = 1'b1;
    for (int z = 0; z < N; z++) begin
      vecs++;
      if (first_sd[z] != 40) begin
        miscompares++;
        $display("FAIL tick_half_timing z=%0d sd_at=%0d want=40", z, first_sd[z]);
      end
    end
  endtask

  task automatic test_off_recovery();
    int first_sd;
    do_reset('0);
    repeat (22) step();
    infra[0] = 1'b1;
    step();
    vecs++;
    if (lamp_on !== 4'b0001) begin
      miscompares++;
      $display("FAIL off_recover lamp_on=%b want=0001", lamp_on);
    end
    infra[0] = 1'b0;
    first_sd = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL off_count cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
      if (shutdown[0] && first_sd < 0) first_sd = k;
    end
    vecs++;
    if (first_sd != 21) begin
      miscompares++;
      $display("FAIL off_recount sd_at=%0d want=21", first_sd);
    end
  endtask

  task automatic test_async_reset();
    do_reset('0);
    repeat (17) step();
    vecs++;
    if (warn !== 4'hF) begin
      miscompares++;
      $display("FAIL pre_reset_warn warn=%h want=f", warn);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    vecs++;
    if ({lamp_on, warn, shutdown, any_active} !== {4'hF, 4'h0, 4'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL async_reset got=%h want=%h", {lamp_on, warn, shutdown, any_active}, 13'h1E01);
    end
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL async_hold cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
    end
    rst = 1'b1;
  endtask

`ifdef MANUAL_OVERRIDE_EN
  task automatic test_override();
    int first_sd, pulses;
    do_reset('0);
    ovr[0] = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs() || lamp_on[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL override cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
      if (shutdown[0]) pulses++;
    end
    ovr[0] = 1'b0;
    first_sd = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (shutdown[0] && first_sd < 0) first_sd = k;
    end
    vecs++;
    if (pulses != 0 || first_sd != 21) begin
      miscompares++;
      $display("FAIL override_release pulses=%0d sd_at=%0d want 0/21", pulses, first_sd);
    end
  endtask
`endif

  task automatic test_random();
    do_reset('0);
    for (int k = 1; k <= 3000; k++) begin
      for (int z = 0; z < N; z++) begin
        infra[z] = ($urandom_range(0, 39) == 0);
        en[z]    = ($urandom_range(0, 9) != 0);
`ifdef MANUAL_OVERRIDE_EN
        ovr[z]   = ($urandom_range(0, 49) == 0);
`endif
      end
      tick      = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 24) == 0);
      cfg_zone  = ZW'($urandom_range(0, 7));
      cfg_value = CW'($urandom_range(0, 30));
      step();
      vecs++;
      if ({lamp_on, warn, shutdown, any_active} !== model_outs()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h want=%h", k, {lamp_on, warn, shutdown, any_active}, model_outs());
      end
    end
    cfg_we = 1'b0; tick = 1'b1; en = '1; infra = '0; ovr = '0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_expiry();
    test_presence_abort();
    test_cfg();
    test_enable_freeze();
    test_tick_half();
    test_off_recovery();
    test_async_reset();
`ifdef MANUAL_OVERRIDE_EN
    test_override();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
